led_channel_bank: RTL and testbench

Parametrised multi-channel LED output stage and successor to the single-bit inverting LED path of the Tiny Tapeout user project. Each of `CHANNELS` outputs is independently configured, through a small register write port, for inverted/non-inverted pass-through, constant level, PWM dimming, or gated blink. The block sits between `ui_in` (or internal sources) and `uo_out`, and shares a single prescaled PWM timebase across all channels.

---
 rtl/led_channel_bank.sv | 142 ++++++++++++++
 tb/tb_led_channel_bank.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_channel_bank.sv
// Multi-channel LED output stage: each channel is a pass-through, constant, PWM or blink
// source with optional inversion, driven from one shared prescaled PWM timebase.
module led_channel_bank #(
  parameter int CHANNELS = 8,
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4,
  localparam int ADDR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CFG_W  = PWM_BITS + 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [CHANNELS-1:0] in_bits,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [CFG_W-1:0]    cfg_wdata,
  output logic [CFG_W-1:0]    cfg_rdata,
  output logic [CHANNELS-1:0] led_out,
  output logic                period_tick
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  // Reset config makes every channel a plain inverter.
  localparam logic [CFG_W-1:0] CFG_RST = {2'b00, 1'b1, {PWM_BITS{1'b0}}};

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_CONST = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                blink_ph_q, blink_ph_d;
  logic [CHANNELS-1:0] led_out_q, led_out_d;
  logic [CFG_W-1:0]    rdata_q, rdata_d;
  logic                tick_q, tick_d;
  logic [CFG_W-1:0]    cfg_q [CHANNELS];
  logic [CFG_W-1:0]    cfg_d [CHANNELS];

  logic                step;
  logic                wrap;
  logic [CHANNELS-1:0] led_raw;
  mode_e               ch_mode;
  logic [PWM_BITS-1:0] ch_duty;
  logic                ch_val;

  // Shared timebase: prescaler -> PWM counter -> blink phase.
  always_comb begin
    step       = ena && (pre_cnt_q == PRE_LAST);
    wrap       = step && (pwm_cnt_q == {PWM_BITS{1'b1}});
    pre_cnt_d  = pre_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    blink_ph_d = blink_ph_q;
    if (ena) begin
      pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + PRE_W'(1);
    end
    if (step) begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end
    if (wrap) begin
      blink_ph_d = ~blink_ph_q;
    end
    // Registered, so high in the cycle where pwm_cnt first holds 0.
    tick_d = wrap;
  end

  always_comb begin
    led_raw = '0;
    ch_mode = MODE_PASS;
    ch_duty = '0;
    ch_val  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_mode = mode_e'(cfg_q[i][CFG_W-1 -: 2]);
      ch_duty = cfg_q[i][PWM_BITS-1:0];
      case (ch_mode)
        MODE_PASS:  ch_val = in_bits[i];
        MODE_CONST: ch_val = 1'b0;
        MODE_PWM:   ch_val = (pwm_cnt_q < ch_duty);
        MODE_BLINK: ch_val = in_bits[i] & blink_ph_q;
        default:    ch_val = 1'b0;
      endcase
      led_raw[i] = ch_val ^ cfg_q[i][PWM_BITS];
    end
    led_out_d = ena ? led_raw : led_out_q;
  end

  // cfg_we is a single-cycle strobe with no back-pressure: the write always lands at the
  // edge where it is seen, and addresses with no channel behind them are dropped.
  always_comb begin
    cfg_d = cfg_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_we && (cfg_addr == ADDR_W'(i))) begin
        cfg_d[i] = cfg_wdata;
      end
    end
  end

  // Readback samples the pre-write contents, so a same-cycle write returns the old value.
  always_comb begin
    rdata_d = rdata_q;
    if (ena) begin
      rdata_d = '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg_addr == ADDR_W'(i)) begin
          rdata_d = cfg_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      blink_ph_q <= 1'b0;
      led_out_q  <= '0;
      rdata_q    <= '0;
      tick_q     <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        cfg_q[i] <= CFG_RST;
      end
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      blink_ph_q <= blink_ph_d;
      led_out_q  <= led_out_d;
      rdata_q    <= rdata_d;
      tick_q     <= tick_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cfg_q[i] <= cfg_d[i];
      end
    end
  end

  assign led_out     = led_out_q;
  assign cfg_rdata   = rdata_q;
  assign period_tick = tick_q;

endmodule

// File: tb/tb_led_channel_bank.sv
// Directed bench for led_channel_bank: a default 8-channel instance plus a small
// 6-channel, PRESCALE=1 instance that has unmapped addresses to write to.
module tb_led_channel_bank;

  logic        clk = 1'b0;
  logic        rst, ena, cfg_we, period_tick;
  logic [7:0]  in_bits, led_out;
  logic [2:0]  cfg_addr;
  logic [10:0] cfg_wdata, cfg_rdata;

  logic        b_rst, b_ena, b_cfg_we, b_tick;
  logic [5:0]  b_in, b_led;
  logic [2:0]  b_addr;
  logic [6:0]  b_wdata, b_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  led_channel_bank #(.CHANNELS(8), .PWM_BITS(8), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_bits(in_bits), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .led_out(led_out), .period_tick(period_tick)
  );

  led_channel_bank #(.CHANNELS(6), .PWM_BITS(4), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(b_rst), .ena(b_ena), .in_bits(b_in), .cfg_we(b_cfg_we),
    .cfg_addr(b_addr), .cfg_wdata(b_wdata), .cfg_rdata(b_rdata),
    .led_out(b_led), .period_tick(b_tick)
  );

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [10:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step_clk();
    cfg_we    = 1'b0;
  endtask

  task automatic wait_tick(input int bound, output int n);
    n = 0;
    do begin
      step_clk();
      n++;
    end while (!period_tick && n < bound);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, highs, len, cnt, pause_ticks;
    logic prev;
    logic [7:0] duties [3] = '{8'd64, 8'd0, 8'd255};
    int         exp_hi [3] = '{256, 0, 1020};

    rst = 1'b1; ena = 1'b0; in_bits = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    b_rst = 1'b1; b_ena = 1'b0; b_in = '0; b_cfg_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) step_clk();

    push(0); check_pop("rst_led", led_out);
    push(0); check_pop("rst_rdata", cfg_rdata);
    push(0); check_pop("rst_tick", period_tick);
    push(0); check_pop("rst_pwm_cnt", dut.pwm_cnt_q);

    // Inverter regression
    rst = 1'b0; ena = 1'b1; b_rst = 1'b0; b_ena = 1'b1;
    in_bits = 8'h00;
    push(8'hFF); push(11'h100);
    step_clk();
    check_pop("inv_00", led_out);
    check_pop("rd_ch0_rst", cfg_rdata);
    in_bits = 8'hA5;
    push(8'h5A);
    step_clk();
    check_pop("inv_a5", led_out);

    for (int a = 1; a < 8; a++) begin
      cfg_addr = 3'(a);
      push(11'h100);
      step_clk();
      check_pop("rd_rst_ch", cfg_rdata);
    end

    // ch5 = CONST, not inverted, duty 0x3C
    in_bits = 8'h00;
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_wdata = 11'h23C;
    push(11'h100); push(8'hFF);
    step_clk();
    cfg_we = 1'b0;
    check_pop("rd_same_cycle_old", cfg_rdata);
    check_pop("led_before_cfg", led_out);
    push(11'h23C); push(8'hDF);
    step_clk();
    check_pop("rd_ch5_new", cfg_rdata);
    check_pop("led_ch5_const", led_out);
    cfg_write(3'd5, 11'h100);

    // PWM duty sweep on ch0
    for (int i = 0; i < 3; i++) begin
      cfg_write(3'd0, {2'b10, 1'b0, duties[i]});
      push(1); push(exp_hi[i]); push(1024);
      wait_tick(2048, n);
      check_pop("pwm_sync", (n < 2048));
      highs = 0; len = 0;
      do begin
        step_clk();
        len++;
        highs += int'(led_out[0]);
      end while (!period_tick && len < 4096);
      check_pop("pwm_high_cycles", highs);
      check_pop("pwm_period", len);
    end

    // Blink on ch3
    cfg_write(3'd3, {2'b11, 1'b0, 8'h00});
    in_bits = 8'h08;
    wait_tick(4096, n);
    prev = led_out[3]; cnt = 0;
    do begin step_clk(); cnt++; end while (led_out[3] == prev && cnt < 4096);
    push(1); check_pop("blink_align", cnt);
    prev = led_out[3]; cnt = 0;
    do begin step_clk(); cnt++; end while (led_out[3] == prev && cnt < 4096);
    push(1024); check_pop("blink_half_period", cnt);
    in_bits = 8'h00;
    push(0);
    step_clk();
    check_pop("blink_in_low", led_out[3]);

    // ena pause mid-period on ch0 at duty 128
    cfg_write(3'd0, {2'b10, 1'b0, 8'd128});
    wait_tick(4096, n);
    repeat (300) step_clk();
    ena = 1'b0;
    pause_ticks = 0;
    for (int k = 0; k < 100; k++) begin
      step_clk();
      pause_ticks += int'(period_tick);
    end
    push(75); check_pop("pause_pwm_cnt", dut.pwm_cnt_q);
    push(8'hF7); check_pop("pause_led", led_out);
    push(0); check_pop("pause_no_tick", pause_ticks);
    ena = 1'b1;
    wait_tick(4096, n);
    push(724); check_pop("pause_remainder", n);

    // Reset with a simultaneous write
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 11'h2FF; rst = 1'b1;
    step_clk();
    cfg_we = 1'b0; rst = 1'b0;
    push(0); check_pop("rst2_pwm_cnt", dut.pwm_cnt_q);
    push(0); check_pop("rst2_led", led_out);
    push(0); check_pop("rst2_rdata", cfg_rdata);
    in_bits = 8'hA5; cfg_addr = 3'd2;
    push(8'h5A); push(11'h100);
    step_clk();
    check_pop("rst2_inv", led_out);
    check_pop("rst2_write_dropped", cfg_rdata);
    cfg_addr = 3'd0;
    push(11'h100);
    step_clk();
    check_pop("rst2_ch0_default", cfg_rdata);

    // Unmapped-address writes on the 6-channel instance
    b_cfg_we = 1'b1; b_addr = 3'd6; b_wdata = 7'h55;
    step_clk();
    b_addr = 3'd7; b_wdata = 7'h2A;
    step_clk();
    b_cfg_we = 1'b0;
    for (int a = 0; a < 6; a++) begin
      b_addr = 3'(a);
      push(7'h10);
      step_clk();
      check_pop("b_rd_untouched", b_rdata);
    end
    b_addr = 3'd6;
    push(0);
    step_clk();
    check_pop("b_rd_unmapped", b_rdata);
    push(6'h3F); check_pop("b_led_inv", b_led);

    // PRESCALE=1, PWM_BITS=4: period of 16 cycles
    n = 0;
    do begin step_clk(); n++; end while (!b_tick && n < 64);
    n = 0;
    do begin step_clk(); n++; end while (!b_tick && n < 64);
    push(16); check_pop("b_period", n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
